// File: rtl/conv_pkg.sv
// Shared definitions for the convolution-coprocessor instruction controller.
// Holds opcode values, FSM state encoding, instruction field offsets and
// status bit positions used by conv_ctrl_unit and its testbench.
package conv_pkg;

  // Opcodes (instruction[3:0])
  localparam logic [3:0] OPC_CLR_ERR    = 4'b0000;
  localparam logic [3:0] OPC_READ       = 4'b0001;
  localparam logic [3:0] OPC_WRITE      = 4'b0010;
  localparam logic [3:0] OPC_CONV       = 4'b0101;
  localparam logic [3:0] OPC_CONV_TRSP  = 4'b0110;
  localparam logic [3:0] OPC_CONV_ROB   = 4'b0111;
  localparam logic [3:0] OPC_PHOTO_CONV = 4'b1110;
  localparam logic [3:0] OPC_READ_IMAGE = 4'b1111;

  // Instruction field offsets
  localparam int OPC_LSB  = 0;
  localparam int ADDR_LSB = 4;
  localparam int DATA_LSB = 12;

  // Status bit indices: {overflow, timeout, illegal, busy}
  localparam int ST_BUSY     = 0;
  localparam int ST_ILLEGAL  = 1;
  localparam int ST_TIMEOUT  = 2;
  localparam int ST_OVERFLOW = 3;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEM    = 3'd2,
    S_RD_CAP = 3'd3,
    S_EXEC   = 3'd4,
    S_IPU    = 3'd5
  } state_t;

  // Decoded instruction class
  typedef enum logic [2:0] {
    K_CLR = 3'd0,
    K_MEM = 3'd1,
    K_CONV = 3'd2,
    K_IPU = 3'd3,
    K_ILL = 3'd4
  } op_kind_t;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous instruction queue with full/empty flags.
// Latency: a pushed word is visible on rdata_o the cycle after the push.
// Backpressure: push refused while full (even with a same-cycle pop); pop ignored while empty.
// Ports: clk/reset (sync, active-high), push_i/wdata_i write side,
//        pop_i/rdata_o read side (rdata_o = head entry), full_o/empty_o flags.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Storage is not reset; only pointers and occupancy are.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/conv_ctrl_unit.sv
// Instruction controller: queues host words, decodes and sequences regfile/engine/IPU ops.
// Latency: push to FETCH pop 1 cycle, DECODE +1, action +1 (WRITE strobe in cycle 3 after push).
// Backpressure: instr_ready=0 when queue full; pushes then are dropped and flag overflow.
// Ports: clk/reset (sync, active-high); instruction/activate_instruction/instr_ready host side;
//        output_reg/output_valid/wait_signal/status host status; rf_* register bank;
//        conv_* convolution engine; ipu_* image-processing unit hand-off.
module conv_ctrl_unit
  import conv_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instruction,
  input  logic              activate_instruction,
  output logic              instr_ready,
  output logic [DATA_W-1:0] output_reg,
  output logic              output_valid,
  output logic              wait_signal,
  output logic [3:0]        status,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              conv_start,
  output logic [1:0]        conv_mode,
  input  logic              conv_done,
  output logic              ipu_cmd_valid,
  output logic [31:0]       ipu_cmd,
  input  logic              ipu_ack
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t            state_q;
  logic [31:0]       fetched_q;
  logic [DATA_W-1:0] output_reg_q;
  logic              output_valid_q;
  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_addr_q;
  logic [DATA_W-1:0] rf_wdata_q;
  logic              conv_start_q;
  logic [1:0]        conv_mode_q;
  logic              ipu_cmd_valid_q;
  logic [31:0]       ipu_cmd_q;
  logic [TW-1:0]     tmo_cnt_q;
  logic              err_ovf_q;
  logic              err_tmo_q;
  logic              err_ill_q;

  logic [31:0]       fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [3:0]        opc;
  op_kind_t          op_kind_d;

  // Push side is not gated: the FIFO itself refuses writes while full.
  assign fifo_pop = (state_q == S_FETCH) && !fifo_empty;

  instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (activate_instruction),
    .wdata_i (instruction),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Inline decoder on the fetched word
  assign opc = fetched_q[OPC_LSB +: 4];

  always_comb begin
    op_kind_d = K_ILL;
    case (opc)
      OPC_CLR_ERR:                             op_kind_d = K_CLR;
      OPC_READ, OPC_WRITE:                     op_kind_d = K_MEM;
      OPC_CONV, OPC_CONV_TRSP, OPC_CONV_ROB:   op_kind_d = K_CONV;
      OPC_PHOTO_CONV, OPC_READ_IMAGE:          op_kind_d = K_IPU;
      default:                                 op_kind_d = K_ILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_FETCH;
      fetched_q       <= '0;
      output_reg_q    <= '0;
      output_valid_q  <= 1'b0;
      rf_we_q         <= 1'b0;
      rf_addr_q       <= '0;
      rf_wdata_q      <= '0;
      conv_start_q    <= 1'b0;
      conv_mode_q     <= '0;
      ipu_cmd_valid_q <= 1'b0;
      ipu_cmd_q       <= '0;
      tmo_cnt_q       <= '0;
      err_ovf_q       <= 1'b0;
      err_tmo_q       <= 1'b0;
      err_ill_q       <= 1'b0;
    end else begin
      output_valid_q <= 1'b0;

      case (state_q)
        S_FETCH: begin
          if (!fifo_empty) begin
            fetched_q <= fifo_rdata;
            state_q   <= S_DECODE;
          end
        end

        S_DECODE: begin
          case (op_kind_d)
            K_MEM: begin
              rf_addr_q <= fetched_q[ADDR_LSB +: ADDR_W];
              if (opc == OPC_WRITE) begin
                rf_we_q    <= 1'b1;
                rf_wdata_q <= fetched_q[DATA_LSB +: DATA_W];
              end
              state_q <= S_MEM;
            end
            K_CONV: begin
              conv_start_q <= 1'b1;
              conv_mode_q  <= opc[1:0];
              tmo_cnt_q    <= '0;
              state_q      <= S_EXEC;
            end
            K_IPU: begin
              ipu_cmd_valid_q <= 1'b1;
              ipu_cmd_q       <= fetched_q;
              tmo_cnt_q       <= '0;
              state_q         <= S_IPU;
            end
            K_CLR: begin
              err_ovf_q <= 1'b0;
              err_tmo_q <= 1'b0;
              err_ill_q <= 1'b0;
              state_q   <= S_FETCH;
            end
            default: begin
              err_ill_q <= 1'b1;
              state_q   <= S_FETCH;
            end
          endcase
        end

        S_MEM: begin
          // Write strobe lasts exactly the MEM cycle; a READ waits one
          // more cycle for the bank's registered read data.
          rf_we_q <= 1'b0;
          state_q <= (opc == OPC_READ) ? S_RD_CAP : S_FETCH;
        end

        S_RD_CAP: begin
          output_reg_q   <= rf_rdata;
          output_valid_q <= 1'b1;
          state_q        <= S_FETCH;
        end

        S_EXEC: begin
          if (conv_done) begin
            conv_start_q <= 1'b0;
            state_q      <= S_FETCH;
          end else if (tmo_cnt_q == TMO_LAST) begin
            conv_start_q <= 1'b0;
            err_tmo_q    <= 1'b1;
            state_q      <= S_FETCH;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
          end
        end

        S_IPU: begin
          if (ipu_ack) begin
            ipu_cmd_valid_q <= 1'b0;
            state_q         <= S_FETCH;
          end else if (tmo_cnt_q == TMO_LAST) begin
            ipu_cmd_valid_q <= 1'b0;
            err_tmo_q       <= 1'b1;
            state_q         <= S_FETCH;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
          end
        end

        default: state_q <= S_FETCH;
      endcase

      // Placed after the decode so a refused push wins over a same-cycle CLR_ERR.
      if (activate_instruction && fifo_full) err_ovf_q <= 1'b1;
    end
  end

  assign instr_ready   = !fifo_full;
  assign wait_signal   = !fifo_empty || (state_q != S_FETCH);
  assign status        = {err_ovf_q, err_tmo_q, err_ill_q, (state_q != S_FETCH)};
  assign output_reg    = output_reg_q;
  assign output_valid  = output_valid_q;
  assign rf_we         = rf_we_q;
  assign rf_addr       = rf_addr_q;
  assign rf_wdata      = rf_wdata_q;
  assign conv_start    = conv_start_q;
  assign conv_mode     = conv_mode_q;
  assign ipu_cmd_valid = ipu_cmd_valid_q;
  assign ipu_cmd       = ipu_cmd_q;

endmodule
